// File: rtl/victim_cache_nway.sv
// victim_cache_nway: fully-associative victim cache with FIFO/LRU replacement and dirty write-back; define VICTIM_CACHE_STATS_EN to add stat counters
module victim_cache_nway #(
  parameter int TAG_WIDTH  = 27,
  parameter int LINE_BYTES = 16,
  parameter int NUM_WAYS   = 4,
  parameter int REPL_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    vc_ready,
  input  logic                    probe_valid,
  input  logic [TAG_WIDTH-1:0]    probe_tag,
  output logic                    probe_ready,
  output logic                    probe_hit,
  output logic                    probe_dirty,
  output logic [LINE_BYTES*8-1:0] probe_line,
  input  logic                    evict_valid,
  input  logic [TAG_WIDTH-1:0]    evict_tag,
  input  logic [LINE_BYTES*8-1:0] evict_line,
  input  logic                    evict_dirty,
  output logic                    evict_ack,
  output logic                    mem_req,
  output logic                    mem_req_write,
  output logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic [LINE_BYTES*8-1:0] mem_req_wdata,
  input  logic                    mem_resp_valid
`ifdef VICTIM_CACHE_STATS_EN
  ,
  output logic [31:0]             stat_probes,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_writebacks
`endif
);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int IW = $clog2(NUM_WAYS);
  typedef enum logic [2:0] {IDLE, PROBE, EVICT, WB_REQ, WB_WAIT} state_t;
  state_t st;
  logic [NUM_WAYS-1:0] valid, dirty;
  logic [TAG_WIDTH-1:0] tags [NUM_WAYS];
  logic [LINE_W-1:0] lines [NUM_WAYS];
  logic [IW-1:0] age [NUM_WAYS];
  logic [IW-1:0] fifo_ptr, w_idx, p_idx, e_idx, f_idx, l_idx, vict, i_idx;
  logic p_hit, e_hit, free, v_dirty, inst, repl, accept_e;
  logic [TAG_WIDTH-1:0] l_tag;
  logic [LINE_W-1:0] l_line;
  logic l_dirty;
  // tag match, lowest free way, oldest way and the install decision
  always_comb begin
    p_hit = 1'b0;
    e_hit = 1'b0;
    free = 1'b0;
    p_idx = '0;
    e_idx = '0;
    f_idx = '0;
    l_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == probe_tag) begin
        p_hit = 1'b1;
        p_idx = IW'(i);
      end
      if (valid[i] && tags[i] == l_tag) begin
        e_hit = 1'b1;
        e_idx = IW'(i);
      end
      if (!valid[i]) begin
        free = 1'b1;
        f_idx = IW'(i);
      end
    end
    for (int i = 1; i < NUM_WAYS; i++)
      if (age[i] > age[l_idx]) l_idx = IW'(i);
    vict = e_hit ? e_idx : free ? f_idx : (REPL_MODE == 1) ? l_idx : fifo_ptr;
    v_dirty = !e_hit && !free && dirty[vict];
    inst = (st == EVICT && !v_dirty) || (st == WB_WAIT && mem_resp_valid);
    repl = inst && (st == WB_WAIT || (!e_hit && !free));
    i_idx = (st == WB_WAIT) ? w_idx : vict;
    accept_e = st == IDLE && !probe_valid && evict_valid && !evict_ack;
  end
  // line storage and the captured eviction request; no reset needed since valid bits gate them
  always_ff @(posedge clk) begin
    if (accept_e) begin
      l_tag <= evict_tag;
      l_line <= evict_line;
      l_dirty <= evict_dirty;
    end
    if (inst) begin
      tags[i_idx] <= l_tag;
      lines[i_idx] <= l_line;
    end
  end
  // control FSM, per-way state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      valid <= '0;
      dirty <= '0;
      fifo_ptr <= '0;
      w_idx <= '0;
      for (int i = 0; i < NUM_WAYS; i++) age[i] <= '0;
      vc_ready <= 1'b1;
      probe_ready <= 1'b0;
      probe_hit <= 1'b0;
      probe_dirty <= 1'b0;
      probe_line <= '0;
      evict_ack <= 1'b0;
      mem_req <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_tag <= '0;
      mem_req_wdata <= '0;
`ifdef VICTIM_CACHE_STATS_EN
      stat_probes <= '0;
      stat_hits <= '0;
      stat_writebacks <= '0;
`endif
    end else begin
      probe_ready <= 1'b0;
      probe_hit <= 1'b0;
      probe_dirty <= 1'b0;
      probe_line <= '0;
      evict_ack <= 1'b0;
      case (st)
        IDLE: begin
          if (probe_valid) begin
            st <= PROBE;
            vc_ready <= 1'b0;
            probe_ready <= 1'b1;
            probe_hit <= p_hit;
            probe_dirty <= p_hit && dirty[p_idx];
            probe_line <= p_hit ? lines[p_idx] : '0;
`ifdef VICTIM_CACHE_STATS_EN
            if (stat_probes != '1) stat_probes <= stat_probes + 1'b1;
            if (p_hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
`endif
            if (p_hit) begin
              valid[p_idx] <= 1'b0;
              dirty[p_idx] <= 1'b0;
              for (int i = 0; i < NUM_WAYS; i++)
                if (valid[i] && age[i] > age[p_idx]) age[i] <= age[i] - 1'b1;
            end
          end else if (accept_e) begin
            st <= EVICT;
            vc_ready <= 1'b0;
          end
        end
        PROBE: begin
          st <= IDLE;
          vc_ready <= 1'b1;
        end
        EVICT: begin
          if (v_dirty) begin
            st <= WB_REQ;
            mem_req <= 1'b1;
            mem_req_write <= 1'b1;
            mem_req_tag <= tags[vict];
            mem_req_wdata <= lines[vict];
            w_idx <= vict;
          end else begin
            st <= IDLE;
            vc_ready <= 1'b1;
            evict_ack <= 1'b1;
          end
        end
        WB_REQ: st <= WB_WAIT;
        WB_WAIT: begin
          if (mem_resp_valid) begin
            st <= IDLE;
            vc_ready <= 1'b1;
            evict_ack <= 1'b1;
            mem_req <= 1'b0;
            mem_req_write <= 1'b0;
`ifdef VICTIM_CACHE_STATS_EN
            if (stat_writebacks != '1) stat_writebacks <= stat_writebacks + 1'b1;
`endif
          end
        end
        default: st <= IDLE;
      endcase
      if (inst) begin
        valid[i_idx] <= 1'b1;
        dirty[i_idx] <= l_dirty | (e_hit & dirty[i_idx]);
        for (int i = 0; i < NUM_WAYS; i++)
          if (IW'(i) == i_idx) age[i] <= '0;
          else if (valid[i] && (!valid[i_idx] || age[i] < age[i_idx])) age[i] <= age[i] + 1'b1;
      end
      if (repl) fifo_ptr <= fifo_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_victim_cache_nway.sv
// tb_victim_cache_nway: directed checks of a FIFO and an LRU instance driven by shared stimulus
module tb_victim_cache_nway;
  localparam int TW = 27;
  localparam int LW = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic probe_valid = 1'b0;
  logic [TW-1:0] probe_tag = '0;
  logic evict_valid = 1'b0;
  logic [TW-1:0] evict_tag = '0;
  logic [LW-1:0] evict_line = '0;
  logic evict_dirty = 1'b0;
  logic mem_resp_valid = 1'b0;
  logic [1:0] vc_ready, probe_ready, probe_hit, probe_dirty, evict_ack, mem_req, mem_req_write;
  logic [LW-1:0] probe_line [2];
  logic [TW-1:0] mem_req_tag [2];
  logic [LW-1:0] mem_req_wdata [2];
`ifdef VICTIM_CACHE_STATS_EN
  logic [31:0] stat_probes [2];
  logic [31:0] stat_hits [2];
  logic [31:0] stat_writebacks [2];
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // instance 0 uses FIFO replacement, instance 1 uses LRU
  for (genvar g = 0; g < 2; g++) begin : g_dut
    victim_cache_nway #(.TAG_WIDTH(TW), .LINE_BYTES(16), .NUM_WAYS(4), .REPL_MODE(g)) u_dut (
      .clk(clk), .rst(rst), .vc_ready(vc_ready[g]),
      .probe_valid(probe_valid), .probe_tag(probe_tag), .probe_ready(probe_ready[g]),
      .probe_hit(probe_hit[g]), .probe_dirty(probe_dirty[g]), .probe_line(probe_line[g]),
      .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_line(evict_line),
      .evict_dirty(evict_dirty), .evict_ack(evict_ack[g]),
      .mem_req(mem_req[g]), .mem_req_write(mem_req_write[g]), .mem_req_tag(mem_req_tag[g]),
      .mem_req_wdata(mem_req_wdata[g]), .mem_resp_valid(mem_resp_valid)
`ifdef VICTIM_CACHE_STATS_EN
      , .stat_probes(stat_probes[g]), .stat_hits(stat_hits[g]), .stat_writebacks(stat_writebacks[g])
`endif
    );
  end

  task automatic chk(input string name, input int d, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", name, d, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] ln(input logic [15:0] t, input logic [15:0] s);
    return {4{s, t}};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    probe_valid = 1'b0;
    evict_valid = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst vc_ready", d, LW'(vc_ready[d]), LW'(1'b1));
      chk("rst probe_ready", d, LW'(probe_ready[d]), '0);
      chk("rst probe_line", d, probe_line[d], '0);
      chk("rst evict_ack", d, LW'(evict_ack[d]), '0);
      chk("rst mem_req", d, LW'(mem_req[d]), '0);
      chk("rst mem_req_tag", d, LW'(mem_req_tag[d]), '0);
`ifdef VICTIM_CACHE_STATS_EN
      chk("rst stat_probes", d, LW'(stat_probes[d]), '0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // present one eviction; if wb, expect write-back of wb_tag/wb_line answered after 5 held cycles
  task automatic evict(input logic [TW-1:0] t, input logic [LW-1:0] l, input logic dty,
                       input logic wb, input logic [TW-1:0] wb_tag, input logic [LW-1:0] wb_line);
    evict_valid = 1'b1;
    evict_tag = t;
    evict_line = l;
    evict_dirty = dty;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("evict ack@1", d, LW'(evict_ack[d]), '0);
      chk("evict vc_ready busy", d, LW'(vc_ready[d]), '0);
    end
    @(negedge clk);
    if (wb) begin
      for (int k = 0; k < 5; k++) begin
        for (int d = 0; d < 2; d++) begin
          chk("wb mem_req", d, LW'(mem_req[d]), LW'(1'b1));
          chk("wb mem_req_write", d, LW'(mem_req_write[d]), LW'(1'b1));
          chk("wb mem_req_tag", d, LW'(mem_req_tag[d]), LW'(wb_tag));
          chk("wb mem_req_wdata", d, mem_req_wdata[d], wb_line);
          chk("wb ack early", d, LW'(evict_ack[d]), '0);
        end
        @(negedge clk);
      end
      mem_resp_valid = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      chk("evict ack", d, LW'(evict_ack[d]), LW'(1'b1));
      chk("evict mem_req idle", d, LW'(mem_req[d]), '0);
    end
    evict_valid = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("evict ack pulse", d, LW'(evict_ack[d]), '0);
  endtask

  // hit[d] is the expected hit for dut d; line/dirty apply only where a hit is expected
  task automatic probe(input logic [TW-1:0] t, input logic [1:0] hit, input logic dty, input logic [LW-1:0] l);
    probe_valid = 1'b1;
    probe_tag = t;
    @(negedge clk);
    probe_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("probe_ready", d, LW'(probe_ready[d]), LW'(1'b1));
      chk($sformatf("probe_hit %0h", t), d, LW'(probe_hit[d]), LW'(hit[d]));
      chk($sformatf("probe_dirty %0h", t), d, LW'(probe_dirty[d]), LW'(hit[d] & dty));
      chk($sformatf("probe_line %0h", t), d, probe_line[d], hit[d] ? l : '0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("probe_ready pulse", d, LW'(probe_ready[d]), '0);
      chk("probe vc_ready", d, LW'(vc_ready[d]), LW'(1'b1));
    end
  endtask

  initial begin
    // clean fill, exclusive probe hit, then miss
    reset_dut();
    for (int t = 16'h10; t <= 16'h13; t++) evict(TW'(t), ln(16'(t), 16'h1), 1'b0, 1'b0, '0, '0);
    probe(TW'(16'h12), 2'b11, 1'b0, ln(16'h12, 16'h1));
    probe(TW'(16'h12), 2'b00, 1'b0, '0);
    // dirty fill, two write-backs, dirty-OR update
    reset_dut();
    for (int t = 16'h10; t <= 16'h13; t++) evict(TW'(t), ln(16'(t), 16'h2), 1'b1, 1'b0, '0, '0);
    evict(TW'(16'h20), ln(16'h20, 16'h2), 1'b1, 1'b1, TW'(16'h10), ln(16'h10, 16'h2));
    evict(TW'(16'h21), ln(16'h21, 16'h2), 1'b1, 1'b1, TW'(16'h11), ln(16'h11, 16'h2));
    evict(TW'(16'h13), ln(16'h13, 16'h3), 1'b0, 1'b0, '0, '0);
    probe(TW'(16'h13), 2'b11, 1'b1, ln(16'h13, 16'h3));
    probe(TW'(16'h10), 2'b00, 1'b0, '0);
    // update-only evict, then replacements that diverge between FIFO and LRU
    reset_dut();
    for (int t = 16'h10; t <= 16'h13; t++) evict(TW'(t), ln(16'(t), 16'h4), 1'b0, 1'b0, '0, '0);
    evict(TW'(16'h11), ln(16'h11, 16'h5), 1'b0, 1'b0, '0, '0);
    evict(TW'(16'h30), ln(16'h30, 16'h4), 1'b0, 1'b0, '0, '0);
    evict(TW'(16'h31), ln(16'h31, 16'h4), 1'b0, 1'b0, '0, '0);
    probe(TW'(16'h11), 2'b10, 1'b0, ln(16'h11, 16'h5));
    probe(TW'(16'h12), 2'b01, 1'b0, ln(16'h12, 16'h4));
    probe(TW'(16'h10), 2'b00, 1'b0, '0);
    probe(TW'(16'h30), 2'b11, 1'b0, ln(16'h30, 16'h4));
    // probe and evict raised together: probe first, ack after
    probe_valid = 1'b1;
    probe_tag = TW'(16'h13);
    evict_valid = 1'b1;
    evict_tag = TW'(16'h40);
    evict_line = ln(16'h40, 16'h4);
    evict_dirty = 1'b0;
    @(negedge clk);
    probe_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("both probe_ready", d, LW'(probe_ready[d]), LW'(1'b1));
      chk("both probe_hit", d, LW'(probe_hit[d]), LW'(1'b1));
      chk("both ack@1", d, LW'(evict_ack[d]), '0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("both ack early", d, LW'(evict_ack[d]), '0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("both ack", d, LW'(evict_ack[d]), LW'(1'b1));
    evict_valid = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("both ack pulse", d, LW'(evict_ack[d]), '0);
    probe(TW'(16'h40), 2'b11, 1'b0, ln(16'h40, 16'h4));
    // reset during write-back wait
    reset_dut();
    for (int t = 16'h10; t <= 16'h13; t++) evict(TW'(t), ln(16'(t), 16'h6), 1'b1, 1'b0, '0, '0);
    evict_valid = 1'b1;
    evict_tag = TW'(16'h50);
    evict_line = ln(16'h50, 16'h6);
    evict_dirty = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("pre-rst mem_req", d, LW'(mem_req[d]), LW'(1'b1));
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("async mem_req drop", d, LW'(mem_req[d]), '0);
    evict_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("post-rst no ack", d, LW'(evict_ack[d]), '0);
        chk("post-rst mem_req", d, LW'(mem_req[d]), '0);
      end
    end
    probe(TW'(16'h10), 2'b00, 1'b0, '0);
    probe(TW'(16'h50), 2'b00, 1'b0, '0);
    probe(TW'(16'h13), 2'b00, 1'b0, '0);
    // three probes with one hit plus one write-back
    reset_dut();
    for (int t = 16'h10; t <= 16'h13; t++) evict(TW'(t), ln(16'(t), 16'h7), 1'b1, 1'b0, '0, '0);
    evict(TW'(16'h20), ln(16'h20, 16'h7), 1'b1, 1'b1, TW'(16'h10), ln(16'h10, 16'h7));
    probe(TW'(16'h11), 2'b11, 1'b1, ln(16'h11, 16'h7));
    probe(TW'(16'h98), 2'b00, 1'b0, '0);
    probe(TW'(16'h99), 2'b00, 1'b0, '0);
`ifdef VICTIM_CACHE_STATS_EN
    for (int d = 0; d < 2; d++) begin
      chk("stat_probes", d, LW'(stat_probes[d]), LW'(32'd3));
      chk("stat_hits", d, LW'(stat_hits[d]), LW'(32'd1));
      chk("stat_writebacks", d, LW'(stat_writebacks[d]), LW'(32'd1));
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
